// File: rtl/mdr_mem_controller.sv
// mdr_mem_controller
// Memory Data Register plus memory-access sequencer. Holds the MAR and MDR,
// drives the MDR onto the bus multiplexer, and runs single-word read/write
// transactions against the RAM. Each transaction uses a ready handshake,
// variable wait states and a timeout abort.
//
// Ports:
//   clock, clear         rising-edge clock, asynchronous active-high reset
//   bus_in               datapath bus value (source for MAR / MDR loads)
//   mar_in, mdr_in       load strobes for MAR / MDR (honoured only while idle)
//   mem_read, mem_write  transaction requests (read wins if both are set)
//   mem_rdata, mem_ready RAM read data and access-complete handshake
//   mdr_out, mem_wdata   MDR contents
//   mem_addr             MAR contents
//   mem_rd_en, mem_wr_en access in progress, by direction
//   busy                 any transaction in progress
//   done                 one-cycle pulse when a transaction ends (ok or timeout)
//   timeout_err          sticky flag: the last transaction timed out
module mdr_mem_controller #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mdr_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    // The wait counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits
    // suffice; a TIMEOUT of 1 still needs one bit.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              done_q;
    logic              timeout_err_q;

    // Sequencer and register file in one block. Loads are only honoured in
    // IDLE, and the request decision uses the same edge, so a load paired with
    // a request is already visible to the transaction it starts. While waiting
    // the counter stops one short of TIMEOUT: that last unready edge aborts
    // instead of counting, which bounds the wait to TIMEOUT cycles.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q       <= IDLE;
            mar_q         <= '0;
            mdr_q         <= '0;
            wait_cnt_q    <= '0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mar_in) begin
                        mar_q <= bus_in[ADDR_W-1:0];
                    end
                    if (mdr_in) begin
                        mdr_q <= bus_in;
                    end
                    if (mem_read || mem_write) begin
                        state_q       <= mem_read ? RD_WAIT : WR_WAIT;
                        wait_cnt_q    <= '0;
                        timeout_err_q <= 1'b0;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (mem_ready) begin
                        if (state_q == RD_WAIT) begin
                            mdr_q <= mem_rdata;
                        end
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        state_q       <= IDLE;
                        done_q        <= 1'b1;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Access enables are pure decodes of the registered state, so they are
    // glitch-free and line up exactly with the wait cycles.
    assign mem_rd_en   = (state_q == RD_WAIT);
    assign mem_wr_en   = (state_q == WR_WAIT);
    assign busy        = mem_rd_en | mem_wr_en;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign mdr_out     = mdr_q;
    assign mem_wdata   = mdr_q;
    assign mem_addr    = mar_q;

endmodule

// File: tb/tb_mdr_mem_controller.sv
// tb_mdr_mem_controller
// Scoreboard bench for mdr_mem_controller. The driver keeps a transaction-level
// model of MAR/MDR/timeout state and pushes one expectation per accepted
// request; an independent monitor pops an expectation on every done pulse and
// compares the final register state and the number of enable cycles seen.
module tb_mdr_mem_controller;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 9;
   localparam int TIMEOUT = 15;

   logic              clock = 1'b0;
   logic              clear = 1'b1;
   logic [DATA_W-1:0] bus_in = '0;
   logic              mar_in = 1'b0;
   logic              mdr_in = 1'b0;
   logic              mem_read = 1'b0;
   logic              mem_write = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_ready = 1'b0;
   logic [DATA_W-1:0] mdr_out;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rd_en;
   logic              mem_wr_en;
   logic              busy;
   logic              done;
   logic              timeout_err;

   mdr_mem_controller #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clock(clock),
      .clear(clear),
      .bus_in(bus_in),
      .mar_in(mar_in),
      .mdr_in(mdr_in),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .mdr_out(mdr_out),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rd_en(mem_rd_en),
      .mem_wr_en(mem_wr_en),
      .busy(busy),
      .done(done),
      .timeout_err(timeout_err)
   );

   // 10-unit clock period
   always #5 clock = ~clock;

   typedef struct {
      bit                isRead;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] mdrStart;
      logic [DATA_W-1:0] mdrEnd;
      bit                terr;
      int                cycles;
   } exp_t;

   exp_t expQ[$];

   logic [ADDR_W-1:0] refMar = '0;
   logic [DATA_W-1:0] refMdr = '0;

   int checkCount   = 0;
   int errorCount   = 0;
   int doneSeen     = 0;
   int doneExpected = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_mdr_out"}, 64'(mdr_out), 64'd0);
      checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      checkOutput({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
      checkOutput({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
      checkOutput({tag, "_wr_en"}, 64'(mem_wr_en), 64'd0);
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
      checkOutput({tag, "_done"}, 64'(done), 64'd0);
      checkOutput({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
   endtask

   // Monitor: counts enable cycles between done pulses, checks that MAR/MDR
   // hold steady while busy, and retires one expectation per done pulse.
   int  rdCycles   = 0;
   int  wrCycles   = 0;
   int  busyCycles = 0;
   bit  prevDone   = 1'b0;

   always @(negedge clock) begin
      exp_t e;
      if (clear) begin
         rdCycles   = 0;
         wrCycles   = 0;
         busyCycles = 0;
         prevDone   = 1'b0;
      end else begin
         if (mem_rd_en) rdCycles++;
         if (mem_wr_en) wrCycles++;
         if (busy) busyCycles++;
         if (busy && expQ.size() > 0) begin
            checkOutput("busy_addr", 64'(mem_addr), 64'(expQ[0].addr));
            checkOutput("busy_mdr", 64'(mdr_out), 64'(expQ[0].mdrStart));
         end
         if (done) begin
            doneSeen++;
            checkOutput("done_width", 64'(prevDone), 64'd0);
            if (expQ.size() == 0) begin
               checkOutput("unexpected_done", 64'(done), 64'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("done_mdr", 64'(mdr_out), 64'(e.mdrEnd));
               checkOutput("done_wdata", 64'(mem_wdata), 64'(e.mdrEnd));
               checkOutput("done_addr", 64'(mem_addr), 64'(e.addr));
               checkOutput("done_terr", 64'(timeout_err), 64'(e.terr));
               checkOutput("done_busy", 64'(busy), 64'd0);
               checkOutput("rd_cycles", 64'(rdCycles), 64'(e.isRead ? e.cycles : 0));
               checkOutput("wr_cycles", 64'(wrCycles), 64'(e.isRead ? 0 : e.cycles));
               checkOutput("busy_cycles", 64'(busyCycles), 64'(e.cycles));
            end
            rdCycles   = 0;
            wrCycles   = 0;
            busyCycles = 0;
         end
         prevDone = done;
      end
   end

   // Driver: called shortly after a rising edge with the DUT idle. Applies
   // loads/requests, updates the transaction model, then plays out the RAM
   // side: delay unready cycles followed by one ready cycle (delay >= TIMEOUT
   // means the RAM never answers). While busy the strobes carry random noise
   // that the DUT must ignore.
   task automatic applyStimulus(input bit rd, input bit wr, input bit lm, input bit ld,
                                input logic [DATA_W-1:0] busVal, input logic [DATA_W-1:0] rdata,
                                input int delay);
      exp_t e;
      if (lm) refMar = busVal[ADDR_W-1:0];
      if (ld) refMdr = busVal;
      bus_in    = busVal;
      mar_in    = lm;
      mdr_in    = ld;
      mem_read  = rd;
      mem_write = wr;
      mem_ready = 1'($urandom % 2);
      if (rd || wr) begin
         e.isRead   = rd;
         e.addr     = refMar;
         e.mdrStart = refMdr;
         e.terr     = (delay >= TIMEOUT);
         e.cycles   = e.terr ? TIMEOUT : delay + 1;
         if (rd && !e.terr) refMdr = rdata;
         e.mdrEnd   = refMdr;
         expQ.push_back(e);
         doneExpected++;
      end
      @(posedge clock); #1;
      if (rd || wr) begin
         for (int i = 0; i < TIMEOUT; i++) begin
            mar_in    = 1'($urandom % 2);
            mdr_in    = 1'($urandom % 2);
            mem_read  = 1'($urandom % 2);
            mem_write = 1'($urandom % 2);
            bus_in    = (i == 0) ? 32'hFFFF_FFFF : $urandom;
            mem_ready = (i == delay);
            mem_rdata = (i == delay) ? rdata : $urandom;
            @(posedge clock); #1;
            if (i == delay) break;
         end
      end
      mar_in    = 1'b0;
      mdr_in    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_ready = 1'($urandom % 2);
      mem_rdata = $urandom;
      @(posedge clock); #1;
   endtask

   // Watchdog: the run is bounded by construction; this only guards a hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed scenarios, random traffic, reset corner cases.
   initial begin
      int kind;
      int delay;
      logic [DATA_W-1:0] rdata;

      // Power-on reset, then release between edges
      repeat (2) @(posedge clock);
      #1;
      checkAllZero("reset");
      clear = 1'b0;
      #1;
      checkAllZero("release");
      @(posedge clock); #1;

      // Load MAR, then read with ready in the first wait cycle
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0005, 32'h0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 0);

      // Load MDR together with a write, ready after 3 wait cycles
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0, 3);

      // Read with the RAM never answering: timeout, flag stays set while idle
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hCAFE_F00D, TIMEOUT);
      checkOutput("terr_sticky", 64'(timeout_err), 64'd1);

      // Read and write together: the read wins and clears the timeout flag
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hA5A5_0F0F, 2);

      // Ready on the very last permitted wait cycle is still a success
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_01FF, 32'h0BAD_CAFE, TIMEOUT - 1);

      // Random traffic
      for (int n = 0; n < 40; n++) begin
         kind  = int'($urandom % 4);
         rdata = $urandom;
         case ($urandom % 8)
            0:       delay = TIMEOUT;
            1:       delay = TIMEOUT - 1;
            default: delay = int'($urandom % 6);
         endcase
         applyStimulus(kind == 0 || kind == 2, kind == 1 || kind == 2,
                       1'($urandom % 2), 1'($urandom % 2), $urandom, rdata, delay);
      end

      // Make sure MAR/MDR are non-zero so the asynchronous clear is visible
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h8765_4321, 32'h0, 0);

      // Clear asserted mid-cycle: outputs drop without any clock edge
      #2 clear = 1'b1;
      #1;
      checkAllZero("async_clear");
      refMar = '0;
      refMdr = '0;
      @(negedge clock);
      clear = 1'b0;
      #1;
      checkAllZero("clear_release");
      @(posedge clock); #1;

      // Clear during a read wait with ready high: no capture and no done
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0123, 32'h0, 0);
      mem_read = 1'b1;
      @(posedge clock); #1;
      mem_read  = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      #2 clear = 1'b1;
      @(posedge clock); #1;
      checkAllZero("clear_in_wait");
      refMar = '0;
      refMdr = '0;
      mem_ready = 1'b0;
      #2 clear = 1'b0;
      @(posedge clock); #1;

      // A little traffic after the abort to confirm normal operation resumes
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0042, 32'h1357_9BDF, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h2468_ACE0, 32'h0, 0);

      repeat (3) @(posedge clock);
      #1;
      checkOutput("done_count", 64'(doneSeen), 64'(doneExpected));
      checkOutput("queue_empty", 64'(expQ.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
